// File: rtl/instr_cache_pkg.sv
// Shared types and address-slicing helpers for the two-way instruction cache.
package instr_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    REFILL_REQ,
    REFILL_WAIT
  } state_e;

  // Tag field: everything above the set index.
  function automatic logic [31:0] adr_tag(input logic [31:0] adr,
                                          input int log_sets,
                                          input int log_words);
    return adr >> (2 + log_sets + log_words);
  endfunction

  // Set index: the bits just above the word offset.
  function automatic logic [31:0] adr_set(input logic [31:0] adr,
                                          input int log_sets,
                                          input int log_words);
    return (adr >> (2 + log_words)) & ((32'd1 << log_sets) - 32'd1);
  endfunction

  // Word offset within a line.
  function automatic logic [31:0] adr_offset(input logic [31:0] adr,
                                             input int log_words);
    return (adr >> 2) & ((32'd1 << log_words) - 32'd1);
  endfunction

endpackage

// File: rtl/instr_cache_2way_if.sv
// Fetch-side and memory-side handshake signals of the instruction cache.
interface instr_cache_2way_if;

  // core fetch port
  logic        cached_instr_req;
  logic [31:0] cached_instr_adr;
  logic        cached_instr_gnt;
  logic        cached_instr_rvalid;
  logic [31:0] cached_instr_read;

  // instruction memory port
  logic        instr_req;
  logic [31:0] instr_adr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_read;

  // The cache itself: serves the core, masters the memory.
  modport slave (
    input  cached_instr_req, cached_instr_adr, instr_gnt, instr_rvalid, instr_read,
    output cached_instr_gnt, cached_instr_rvalid, cached_instr_read, instr_req, instr_adr
  );

  // The environment: core fetch unit plus instruction memory.
  modport master (
    output cached_instr_req, cached_instr_adr, instr_gnt, instr_rvalid, instr_read,
    input  cached_instr_gnt, cached_instr_rvalid, cached_instr_read, instr_req, instr_adr
  );

endinterface

// File: rtl/instr_cache_way.sv
// One way of the cache: tag, valid and data storage with hit detection.
module instr_cache_way #(
  parameter  int LOG_SETS  = 4,
  parameter  int LOG_WORDS = 2,
  localparam int TAG_W     = 30 - LOG_SETS - LOG_WORDS,
  localparam int SETS      = 1 << LOG_SETS,
  localparam int WORDS     = 1 << LOG_WORDS,
  localparam int OFF_W     = (LOG_WORDS > 0) ? LOG_WORDS : 1
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic [LOG_SETS-1:0] set_i,
  input  logic [OFF_W-1:0]    offset_i,
  input  logic [TAG_W-1:0]    tag_i,
  input  logic [WORDS-1:0]    wr_en_i,
  input  logic [31:0]         wr_data_i,
  input  logic                tag_we_i,
  input  logic                valid_set_i,
  input  logic                flush_clr_i,
  output logic                hit_o,
  output logic                valid_o,
  output logic [31:0]         rdata_o
);

  logic [31:0]      data_q  [SETS][WORDS];
  logic [TAG_W-1:0] tag_q   [SETS];
  logic [SETS-1:0]  valid_q;

  // Line data and tag writes during refill.
  // NOTE: the data and tag arrays have no reset; a line is only ever read when
  // its valid bit is set, and an unreset array can map onto plain RAM.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WORDS; w++) begin
      if (wr_en_i[w]) data_q[set_i][w] <= wr_data_i;
    end
    if (tag_we_i) tag_q[set_i] <= tag_i;
  end

  // Valid bits: cleared by reset or flush, set when a refill completes.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      valid_q <= '0;
    end else if (flush_clr_i) begin
      valid_q <= '0;
    end else if (valid_set_i) begin
      valid_q[set_i] <= 1'b1;
    end
  end

  assign valid_o = valid_q[set_i];
  assign hit_o   = valid_q[set_i] && (tag_q[set_i] == tag_i);
  assign rdata_o = data_q[set_i][offset_i];

endmodule

// File: rtl/instr_cache_2way.sv
// Two-way set-associative instruction cache with burst line refill and LRU.
module instr_cache_2way
  import instr_cache_pkg::*;
#(
  parameter int LOG_SETS  = 4,
  parameter int LOG_WORDS = 2
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic                flush,
  instr_cache_2way_if.slave   bus,
  output logic [31:0]         miss_count
);

  localparam int TAG_W = 30 - LOG_SETS - LOG_WORDS;
  localparam int SETS  = 1 << LOG_SETS;
  localparam int WORDS = 1 << LOG_WORDS;
  localparam int OFF_W = (LOG_WORDS > 0) ? LOG_WORDS : 1;

  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [LOG_SETS-1:0] set_t;
  typedef logic [OFF_W-1:0]    off_t;

  // registered state
  state_e          state_q, state_d;
  off_t            cnt_q, cnt_d;
  tag_t            base_tag_q, base_tag_d;
  set_t            base_set_q, base_set_d;
  logic            victim_q, victim_d;
  logic            flush_pend_q, flush_pend_d;
  logic [SETS-1:0] lru_q, lru_d;
  logic [31:0]     miss_q, miss_d;
  logic [31:0]     rdata_q, rdata_d;

  // core address fields
  tag_t core_tag;
  set_t core_set;
  off_t core_off;

  // way interface
  logic              refilling;
  set_t              way_set;
  tag_t              way_tag;
  logic [1:0]        hit, valid, tag_we, valid_set;
  logic [31:0]       rdata [2];
  logic [WORDS-1:0]  wr_en [2];
  logic              flush_clr;
  logic              gnt;
  logic [31:0]       refill_adr;

  assign core_tag = tag_t'(adr_tag(bus.cached_instr_adr, LOG_SETS, LOG_WORDS));
  assign core_set = set_t'(adr_set(bus.cached_instr_adr, LOG_SETS, LOG_WORDS));
  assign core_off = off_t'(adr_offset(bus.cached_instr_adr, LOG_WORDS));

  // During a refill the ways are addressed by the latched line, otherwise by the core.
  assign refilling = (state_q == REFILL_REQ) || (state_q == REFILL_WAIT);
  assign way_set   = refilling ? base_set_q : core_set;
  assign way_tag   = refilling ? base_tag_q : core_tag;

  for (genvar w = 0; w < 2; w++) begin : g_way
    instr_cache_way #(
      .LOG_SETS  (LOG_SETS),
      .LOG_WORDS (LOG_WORDS)
    ) u_way (
      .clk         (clk),
      .res_n       (res_n),
      .set_i       (way_set),
      .offset_i    (core_off),
      .tag_i       (way_tag),
      .wr_en_i     (wr_en[w]),
      .wr_data_i   (bus.instr_read),
      .tag_we_i    (tag_we[w]),
      .valid_set_i (valid_set[w]),
      .flush_clr_i (flush_clr),
      .hit_o       (hit[w]),
      .valid_o     (valid[w]),
      .rdata_o     (rdata[w])
    );
  end

  // Next-state logic: lookup, miss handling and refill sequencing.
  // NOTE: every signal gets its default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_tag_d   = base_tag_q;
    base_set_d   = base_set_q;
    victim_d     = victim_q;
    flush_pend_d = flush_pend_q;
    lru_d        = lru_q;
    miss_d       = miss_q;
    rdata_d      = rdata_q;
    gnt          = 1'b0;
    wr_en[0]     = '0;
    wr_en[1]     = '0;
    tag_we       = '0;
    valid_set    = '0;
    flush_clr    = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (flush) begin
          flush_clr = 1'b1;
          lru_d     = '0;
        end else if (bus.cached_instr_req) begin
          if (|hit) begin
            gnt             = 1'b1;
            rdata_d         = hit[1] ? rdata[1] : rdata[0];
            lru_d[core_set] = ~hit[1];
            state_d         = RESP;
          end else begin
            if (miss_q != '1) miss_d = miss_q + 32'd1;
            victim_d   = !valid[0] ? 1'b0 : (!valid[1] ? 1'b1 : lru_q[core_set]);
            base_tag_d = core_tag;
            base_set_d = core_set;
            cnt_d      = '0;
            state_d    = REFILL_REQ;
          end
        end
      end

      REFILL_REQ: begin
        flush_pend_d = flush_pend_q | flush;
        if (bus.instr_gnt) state_d = REFILL_WAIT;
      end

      REFILL_WAIT: begin
        flush_pend_d = flush_pend_q | flush;
        if (bus.instr_rvalid) begin
          wr_en[victim_q] = WORDS'(1) << cnt_q;
          if (cnt_q == off_t'(WORDS - 1)) begin
            tag_we[victim_q] = 1'b1;
            if (flush_pend_q || flush) begin
              // A flush arrived mid-refill: drop the new line along with all others.
              flush_clr = 1'b1;
              lru_d     = '0;
            end else begin
              valid_set[victim_q] = 1'b1;
              lru_d[base_set_q]   = ~victim_q;
            end
            flush_pend_d = 1'b0;
            state_d      = IDLE;
          end else begin
            cnt_d   = cnt_q + off_t'(1);
            state_d = REFILL_REQ;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      base_tag_q   <= '0;
      base_set_q   <= '0;
      victim_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      lru_q        <= '0;
      miss_q       <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_tag_q   <= base_tag_d;
      base_set_q   <= base_set_d;
      victim_q     <= victim_d;
      flush_pend_q <= flush_pend_d;
      lru_q        <= lru_d;
      miss_q       <= miss_d;
      rdata_q      <= rdata_d;
    end
  end

  assign refill_adr = (32'({base_tag_q, base_set_q}) << (LOG_WORDS + 2)) | (32'(cnt_q) << 2);

  assign bus.cached_instr_gnt    = gnt;
  assign bus.cached_instr_rvalid = (state_q == RESP);
  assign bus.cached_instr_read   = rdata_q;
  assign bus.instr_req           = (state_q == REFILL_REQ);
  assign bus.instr_adr           = (state_q == REFILL_REQ) ? refill_adr : '0;
  assign miss_count              = miss_q;

endmodule

// File: tb/tb_instr_cache_2way.sv
// Self-checking bench for instr_cache_2way against an LRU-list reference model.
module tb_instr_cache_2way;

  localparam int          LS  = 4;
  localparam int          LW  = 2;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk   = 1'b0;
  logic        res_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] miss_count;

  instr_cache_2way_if bus ();

  instr_cache_2way #(
    .LOG_SETS  (LS),
    .LOG_WORDS (LW)
  ) dut (
    .clk        (clk),
    .res_n      (res_n),
    .flush      (flush),
    .bus        (bus),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // ---------------- reference model: per-set tag lists, most recent first ----------------
  int unsigned mdl_q [16][$];
  int unsigned mdl_miss = 0;

  function automatic int unsigned set_of(input logic [31:0] a);
    return (a >> 4) & 32'hF;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a >> 8;
  endfunction

  function automatic int mdl_find(input int unsigned s, input int unsigned t);
    for (int i = 0; i < mdl_q[s].size(); i++) begin
      if (mdl_q[s][i] == t) return i;
    end
    return -1;
  endfunction

  task automatic mdl_use(input int unsigned s, input int unsigned t);
    int idx;
    idx = mdl_find(s, t);
    if (idx >= 0) mdl_q[s].delete(idx);
    else if (mdl_q[s].size() == 2) mdl_q[s].delete(1);
    mdl_q[s].push_front(t);
  endtask

  task automatic mdl_flush();
    for (int s = 0; s < 16; s++) mdl_q[s].delete();
  endtask

  // ---------------- instruction memory: 1-cycle gnt, rvalid 2 cycles later ----------------
  int          mem_cd = 0;
  int          mem_rv = 0;
  logic [31:0] mem_adr;
  logic [31:0] mem_log[$];

  task automatic mem_step();
    bus.instr_gnt    = 1'b0;
    bus.instr_rvalid = 1'b0;
    if (mem_cd > 0) begin
      mem_cd--;
      if (mem_cd == 0) begin
        bus.instr_rvalid = 1'b1;
        bus.instr_read   = mem_adr ^ KEY;
        mem_rv++;
      end
    end else if (bus.instr_req) begin
      bus.instr_gnt = 1'b1;
      mem_adr       = bus.instr_adr;
      mem_log.push_back(mem_adr);
      mem_cd        = 2;
    end
  endtask

  // One complete core fetch, optionally flushing while the 2nd refill word is granted.
  task automatic fetch(input logic [31:0] a, input bit flush_mid);
    int unsigned s, t;
    bit          exp_hit, flushed;
    int          refills, log0, gnt_at, n_new;
    logic [31:0] base;
    s       = set_of(a);
    t       = tag_of(a);
    exp_hit = (mdl_find(s, t) >= 0);
    refills = exp_hit ? 0 : (flush_mid ? 2 : 1);
    log0    = mem_log.size();
    gnt_at  = -1;
    flushed = 1'b0;
    base    = a & ~32'hF;
    for (int c = 0; c < 200 && gnt_at < 0; c++) begin
      @(negedge clk);
      mem_step();
      flush = 1'b0;
      if (c == 0) begin
        bus.cached_instr_req = 1'b1;
        bus.cached_instr_adr = a;
      end
      if (flush_mid && !flushed && bus.instr_gnt && (mem_log.size() - log0 == 2)) begin
        flush   = 1'b1;
        flushed = 1'b1;
      end
      #1;
      if (bus.cached_instr_gnt) gnt_at = c;
    end
    check("gnt_seen", 32'(gnt_at >= 0), 32'd1);
    check("gnt_in_req_cycle", 32'(gnt_at == 0), 32'(exp_hit));
    n_new = mem_log.size() - log0;
    check("mem_req_count", 32'(n_new), 32'(4 * refills));
    for (int k = 0; k < n_new && k < 4 * refills; k++)
      check("refill_adr", mem_log[log0 + k], base + 32'(4 * (k % 4)));
    if (!exp_hit && flush_mid) mdl_flush();
    mdl_use(s, t);
    mdl_miss += refills;
    @(negedge clk);
    mem_step();
    flush = 1'b0;
    bus.cached_instr_req = 1'b0;
    #1;
    check("rvalid_after_gnt", 32'(bus.cached_instr_rvalid), 32'd1);
    check("read_data", bus.cached_instr_read, a ^ KEY);
    check("miss_count", miss_count, mdl_miss);
    @(negedge clk);
    mem_step();
    #1;
    check("rvalid_one_cycle", 32'(bus.cached_instr_rvalid), 32'd0);
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    mem_step();
    flush = 1'b1;
    @(negedge clk);
    mem_step();
    flush = 1'b0;
    mdl_flush();
  endtask

  // Hang guard.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          r, rv0;
    bit          done;

    bus.cached_instr_req = 1'b0;
    bus.cached_instr_adr = '0;
    bus.instr_gnt        = 1'b0;
    bus.instr_rvalid     = 1'b0;
    bus.instr_read       = '0;

    // reset state
    #12;
    check("rst_gnt", 32'(bus.cached_instr_gnt), 32'd0);
    check("rst_rvalid", 32'(bus.cached_instr_rvalid), 32'd0);
    check("rst_read", bus.cached_instr_read, 32'd0);
    check("rst_instr_req", 32'(bus.instr_req), 32'd0);
    check("rst_instr_adr", bus.instr_adr, 32'd0);
    check("rst_miss", miss_count, 32'd0);
    @(negedge clk);
    res_n = 1'b1;

    // 1: cold miss, 2: hit in the same line
    fetch(32'h0000_0100, 1'b0);
    check("t1_read", bus.cached_instr_read, 32'hA5A5_0100);
    check("t1_miss", miss_count, 32'd1);
    fetch(32'h0000_0108, 1'b0);
    check("t2_miss", miss_count, 32'd1);

    // 3: LRU replacement within set 0
    fetch(32'h0000_0200, 1'b0);
    fetch(32'h0000_0100, 1'b0);
    fetch(32'h0000_0200, 1'b0);
    fetch(32'h0000_0100, 1'b0);
    fetch(32'h0000_0300, 1'b0);
    fetch(32'h0000_0100, 1'b0);
    fetch(32'h0000_0200, 1'b0);
    check("t3_miss", miss_count, 32'd4);

    // 4: back-to-back hits on the 0x100 line
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_step();
      bus.cached_instr_req = 1'b1;
      bus.cached_instr_adr = 32'h100 + 32'(4 * i);
      #1;
      check("b2b_gnt", 32'(bus.cached_instr_gnt), 32'd1);
      if (i > 0) begin
        check("b2b_rvalid", 32'(bus.cached_instr_rvalid), 32'd1);
        check("b2b_read", bus.cached_instr_read, (32'h100 + 32'(4 * (i - 1))) ^ KEY);
      end
      mdl_use(1, 1);
    end
    @(negedge clk);
    mem_step();
    bus.cached_instr_req = 1'b0;
    #1;
    check("b2b_rvalid_last", 32'(bus.cached_instr_rvalid), 32'd1);
    check("b2b_read_last", bus.cached_instr_read, 32'h108 ^ KEY);
    @(negedge clk);
    mem_step();
    #1;
    check("b2b_rvalid_end", 32'(bus.cached_instr_rvalid), 32'd0);

    // 5a: flush beats a simultaneous request, then the request misses
    @(negedge clk);
    mem_step();
    flush = 1'b1;
    bus.cached_instr_req = 1'b1;
    bus.cached_instr_adr = 32'h100;
    #1;
    check("flush_blocks_gnt", 32'(bus.cached_instr_gnt), 32'd0);
    mdl_flush();
    fetch(32'h0000_0100, 1'b0);

    // 5b: flush during a refill forces a second refill
    r = int'(miss_count);
    fetch(32'h0000_0400, 1'b1);
    check("t5_miss_plus2", miss_count, 32'(r + 2));

    // 6: asynchronous reset after the second refill word
    flush_pulse();
    rv0  = mem_rv;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      mem_step();
      if (c == 0) begin
        bus.cached_instr_req = 1'b1;
        bus.cached_instr_adr = 32'h400;
      end
      if (mem_rv - rv0 == 2) done = 1'b1;
    end
    check("t6_two_words", 32'(done), 32'd1);
    @(posedge clk);
    #2;
    check("t6_req_before_rst", 32'(bus.instr_req), 32'd1);
    res_n = 1'b0;
    #1;
    check("t6_req_async", 32'(bus.instr_req), 32'd0);
    check("t6_gnt_async", 32'(bus.cached_instr_gnt), 32'd0);
    check("t6_rvalid_async", 32'(bus.cached_instr_rvalid), 32'd0);
    check("t6_miss_async", miss_count, 32'd0);
    bus.cached_instr_req = 1'b0;
    bus.instr_gnt        = 1'b0;
    bus.instr_rvalid     = 1'b0;
    mem_cd   = 0;
    mdl_miss = 0;
    mdl_flush();
    @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
    bus.instr_rvalid = 1'b1;
    bus.instr_read   = 32'hDEAD_BEEF;
    #1;
    check("t6_late_rvalid_req", 32'(bus.instr_req), 32'd0);
    check("t6_late_rvalid_out", 32'(bus.cached_instr_rvalid), 32'd0);
    @(negedge clk);
    bus.instr_rvalid = 1'b0;
    fetch(32'h0000_0400, 1'b0);
    check("t6_miss_after", miss_count, 32'd1);

    // randomized traffic over 3 tags x 4 sets, with occasional flushes
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 11));
      if (r == 0) begin
        flush_pulse();
      end else begin
        a = (32'($urandom_range(1, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
            (32'($urandom_range(0, 3)) << 2);
        fetch(a, (r == 1) && (mdl_find(set_of(a), tag_of(a)) < 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
